calc_op_sequencer: RTL and testbench

Sequencing controller for the shared 4-function calculator datapath (add/sub/mul/div). It accepts one operation request at a time over a valid/ready handshake and drives the datapath operand and opcode lines from registers. It waits a programmable settle interval, captures the 12-bit result and holds it on a valid/ready response channel until consumed. It sits between the user/key-input logic and the combinational calculator datapath, and is the only driver of that datapath.

---
 rtl/calc_pkg.sv | 28 ++
 rtl/calc_settle_timer.sv | 28 ++
 rtl/calc_op_sequencer.sv | 117 +++++++++++
 tb/tb_calc_op_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: opcodes, widths, FSM states.
// Used by calc_op_sequencer and calc_settle_timer.
package calc_pkg;

  localparam int OPND_W = 10;
  localparam int RES_W  = 12;
  localparam int CNT_W  = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [RES_W-1:0] DIV_ERR_RESULT = 12'hFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } calc_state_e;

  // Divisor occupies the low nibble of the packed operand word for OP_DIV.
  function automatic logic is_div_zero(input logic [1:0] op,
                                       input logic [OPND_W-1:0] opnd);
    return (op == OP_DIV) && (opnd[3:0] == 4'd0);
  endfunction

endpackage

// File: rtl/calc_settle_timer.sv
// Loadable down-counter with a zero flag, used to time datapath settling.
module calc_settle_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load has priority; the count parks at zero rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/calc_op_sequencer.sv
// Request/settle/response sequencer driving the shared calculator datapath.
// Define CALC_DIV_ZERO_CHK_EN to short-circuit divide-by-zero into an error response.
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [OPND_W-1:0] req_operands,
  output logic [OPND_W-1:0] dp_data_in,
  output logic [1:0]        dp_key,
  input  logic [RES_W-1:0]  dp_data_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_result,
  output logic [1:0]        rsp_op,
  output logic              rsp_err,
  output logic [7:0]        op_count
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  calc_state_e state;
  logic        accept;
  logic        div_zero;
  logic        timer_load;
  logic        timer_dec;
  logic        timer_zero;

  assign req_ready  = (state == IDLE);
  assign accept     = req_valid && req_ready;
  assign timer_load = accept && !div_zero;
  assign timer_dec  = (state == SETTLE);

`ifdef CALC_DIV_ZERO_CHK_EN
  assign div_zero = is_div_zero(req_op, req_operands);
`else
  assign div_zero = 1'b0;
`endif

  calc_settle_timer #(
    .CNT_W(CNT_W)
  ) u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .load_val(SETTLE_LOAD),
    .dec     (timer_dec),
    .zero    (timer_zero)
  );

  // Datapath lines only move on a real accept, so the datapath sees stable inputs while settling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dp_data_in <= '0;
      dp_key     <= OP_ADD;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_op     <= OP_ADD;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (div_zero) begin
              rsp_result <= DIV_ERR_RESULT;
              rsp_op     <= OP_DIV;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end else begin
              dp_data_in <= req_operands;
              dp_key     <= req_op;
              state      <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (timer_zero) begin
            rsp_result <= dp_data_out;
            rsp_op     <= dp_key;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 8'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CALC_DIV_ZERO_CHK_EN
  // Error flag is fixed when RESP is entered and held until the next response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err <= 1'b0;
    end else if (accept && div_zero) begin
      rsp_err <= 1'b1;
    end else if ((state == SETTLE) && timer_zero) begin
      rsp_err <= 1'b0;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Self-checking bench for calc_op_sequencer with a behavioural calculator datapath.
// Honours CALC_DIV_ZERO_CHK_EN when choosing divide-by-zero expectations.
module tb_calc_op_sequencer;
  import calc_pkg::*;

  localparam int S = 2;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [9:0]  req_operands;
  logic [9:0]  dp_data_in;
  logic [1:0]  dp_key;
  logic [11:0] dp_data_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [11:0] rsp_result;
  logic [1:0]  rsp_op;
  logic        rsp_err;
  logic [7:0]  op_count;

  int pass_count  = 0;
  int check_count = 0;

  int         exp_count;
  logic [1:0] last_key;
  logic [9:0] last_data;

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [9:0] opnd;
    logic [11:0] res;
    logic       err;
    int         lat;
  } vec_t;

  vec_t vecs[9];

  calc_op_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_operands(req_operands),
    .dp_data_in  (dp_data_in),
    .dp_key      (dp_key),
    .dp_data_out (dp_data_out),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_op      (rsp_op),
    .rsp_err     (rsp_err),
    .op_count    (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic meaning of each opcode on the packed operand word.
  function automatic logic [11:0] calc_ref(input logic [1:0] op, input logic [9:0] opnd);
    int a, b, dd, dv;
    a  = int'(opnd[9:5]);
    b  = int'(opnd[4:0]);
    dd = int'(opnd[9:4]);
    dv = int'(opnd[3:0]);
    case (op)
      OP_ADD: return 12'(a + b);
      OP_SUB: return 12'(a - b);
      OP_MUL: return 12'(a * b);
      default: begin
        if (dv == 0) return {6'h3F, 6'(dd)};
        return {6'(dd / dv), 6'(dd % dv)};
      end
    endcase
  endfunction

  assign dp_data_out = calc_ref(dp_key, dp_data_in);

  function automatic logic div_err_expected(input logic [1:0] op, input logic [9:0] opnd);
`ifdef CALC_DIV_ZERO_CHK_EN
    return (op == OP_DIV) && (opnd[3:0] == 4'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic doReset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("reset_req_ready", req_ready, 1);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_dp_key", dp_key, 0);
    checkOutput("reset_op_count", op_count, 0);
    checkOutput("reset_rsp_result", rsp_result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;
    last_key  = 2'b00;
    last_data = '0;
  endtask

  // Issue one request, check latency/response/datapath lines, then consume it.
  task automatic applyStimulus(input string name, input logic [1:0] op, input logic [9:0] opnd,
                               input logic [11:0] exp_res, input logic exp_err, input int exp_lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_ready"}, req_ready, 1);
    req_op       = op;
    req_operands = opnd;
    req_valid    = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (!exp_err) begin
      last_key  = op;
      last_data = opnd;
    end
    n = 0;
    @(negedge clk);
    checkOutput({name, "_dp_key"}, dp_key, last_key);
    checkOutput({name, "_dp_data"}, dp_data_in, last_data);
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_latency"}, n, exp_lat);
    checkOutput({name, "_result"}, rsp_result, exp_res);
    checkOutput({name, "_op"}, rsp_op, op);
    checkOutput({name, "_err"}, rsp_err, exp_err);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    exp_count = (exp_count + 1) % 256;
    @(negedge clk);
    checkOutput({name, "_consumed"}, rsp_valid, 0);
    checkOutput({name, "_count"}, op_count, exp_count);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, rose, accepts, resps, bad, cyc, last_acc;
    logic [7:0] cnt_before;
    logic [1:0] rop;
    logic [9:0] ropnd;
    logic       rerr;

    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = OP_ADD; req_operands = '0;
    exp_count = 0; last_key = 2'b00; last_data = '0;

    vecs[0] = '{"add_5_3",   OP_ADD, {5'd5, 5'd3},   12'd8,     1'b0, S};
    vecs[1] = '{"sub_10_4",  OP_SUB, {5'd10, 5'd4},  12'd6,     1'b0, S};
    vecs[2] = '{"mul_7_9",   OP_MUL, {5'd7, 5'd9},   12'd63,    1'b0, S};
    vecs[3] = '{"div_20_3",  OP_DIV, {6'd20, 4'd3},  12'h182,   1'b0, S};
    vecs[4] = '{"add_max",   OP_ADD, {5'd31, 5'd31}, 12'd62,    1'b0, S};
`ifdef CALC_DIV_ZERO_CHK_EN
    vecs[5] = '{"div_20_0",  OP_DIV, {6'd20, 4'd0},  12'hFFF,   1'b1, 0};
`else
    vecs[5] = '{"div_20_0",  OP_DIV, {6'd20, 4'd0},  12'hFD4,   1'b0, S};
`endif
    vecs[6] = '{"sub_neg",   OP_SUB, {5'd3, 5'd5},   12'hFFE,   1'b0, S};
    vecs[7] = '{"mul_max",   OP_MUL, {5'd31, 5'd31}, 12'h3C1,   1'b0, S};
    vecs[8] = '{"div_63_15", OP_DIV, {6'd63, 4'd15}, 12'h103,   1'b0, S};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("startup_req_ready", req_ready, 1);
    checkOutput("startup_op_count", op_count, 0);

    for (int i = 0; i < 9; i++)
      applyStimulus(vecs[i].name, vecs[i].op, vecs[i].opnd, vecs[i].res, vecs[i].err, vecs[i].lat);

    // Asynchronous reset after state has moved away from reset values.
    doReset();

    // Reset one cycle into SETTLE must abort the SUB with no response.
    @(negedge clk);
    req_op = OP_SUB; req_operands = {5'd10, 5'd4}; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("abort_rsp_valid", rsp_valid, 0);
    checkOutput("abort_req_ready", req_ready, 1);
    checkOutput("abort_dp_key", dp_key, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0; last_key = 2'b00; last_data = '0;
    rose = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) rose = 1;
    end
    checkOutput("abort_no_response", rose, 0);
    checkOutput("abort_op_count", op_count, 0);

    // Backpressure: MUL held in RESP while a second request waits.
    @(negedge clk);
    req_op = OP_MUL; req_operands = {5'd7, 5'd9}; req_valid = 1'b1;
    @(posedge clk);
    #1 req_op = OP_ADD; req_operands = {5'd1, 5'd2};
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp_latency", n, S);
    for (int c = 0; c < 5; c++) begin
      checkOutput("bp_result_stable", rsp_result, 63);
      checkOutput("bp_valid_held", rsp_valid, 1);
      checkOutput("bp_req_ready_low", req_ready, 0);
      checkOutput("bp_dp_data_held", dp_data_in, {5'd7, 5'd9});
      if (c < 4) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    exp_count++;
    @(negedge clk);
    checkOutput("bp_ready_after_handshake", req_ready, 1);
    checkOutput("bp_count", op_count, exp_count);
    checkOutput("bp_dp_key_before_accept", dp_key, OP_MUL);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_second_accepted", req_ready, 0);
    checkOutput("bp_second_dp_key", dp_key, OP_ADD);
    checkOutput("bp_second_dp_data", dp_data_in, {5'd1, 5'd2});
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp_second_result", rsp_result, 3);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    exp_count++;
    last_key = OP_ADD; last_data = {5'd1, 5'd2};

    // Randomized ops against the reference arithmetic.
    for (int r = 0; r < 40; r++) begin
      rop   = 2'($urandom_range(0, 3));
      ropnd = 10'($urandom);
      if (rop == OP_DIV && $urandom_range(0, 3) == 0) ropnd[3:0] = 4'd0;
      rerr = div_err_expected(rop, ropnd);
      applyStimulus("random", rop, ropnd, rerr ? DIV_ERR_RESULT : calc_ref(rop, ropnd),
                    rerr, rerr ? 0 : S);
    end

    // Streaming 256 ops: one accept every S+2 cycles and op_count wrap.
    doReset();
    @(negedge clk);
    req_op = OP_ADD; req_operands = {5'd1, 5'd2};
    req_valid = 1'b1; rsp_ready = 1'b1;
    accepts = 0; resps = 0; bad = 0; cyc = 0; last_acc = -1; cnt_before = '0;
    while (resps < 256 && cyc < 3000) begin
      if (cyc > 0) @(negedge clk);
      cyc++;
      if (rsp_valid) begin
        resps++;
        if (rsp_result != 12'd3) bad++;
        if (resps == 256) cnt_before = op_count;
      end
      if (req_ready && req_valid) begin
        if (last_acc >= 0 && (cyc - last_acc) != S + 2) bad++;
        last_acc = cyc;
        accepts++;
      end
      @(posedge clk);
      #1;
      if (accepts == 256) req_valid = 1'b0;
    end
    rsp_ready = 1'b0;
    @(negedge clk);
    checkOutput("stream_responses", resps, 256);
    checkOutput("stream_accepts", accepts, 256);
    checkOutput("stream_spacing_and_results", bad, 0);
    checkOutput("stream_count_before_wrap", cnt_before, 255);
    checkOutput("stream_count_wrapped", op_count, 0);
    checkOutput("stream_idle_after", req_ready, 1);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
